// File: rtl/gb_alu_pkg.sv
// Shared definitions for the Game Boy ALU path: command codes, flag bit
// positions, sequencer state encoding and the latched request payload.
package gb_alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned WIDE_W = 16;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned CMD_W  = 3;

    localparam logic [CMD_W-1:0] CMD_ADD = 3'b000;
    localparam logic [CMD_W-1:0] CMD_ADC = 3'b001;
    localparam logic [CMD_W-1:0] CMD_SUB = 3'b010;
    localparam logic [CMD_W-1:0] CMD_SBC = 3'b011;
    localparam logic [CMD_W-1:0] CMD_AND = 3'b100;
    localparam logic [CMD_W-1:0] CMD_XOR = 3'b101;
    localparam logic [CMD_W-1:0] CMD_OR  = 3'b110;
    localparam logic [CMD_W-1:0] CMD_CP  = 3'b111;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_H = 1;
    localparam int unsigned FLAG_C = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_P_LO    = 3'd1,
        ST_P_HI    = 3'd2,
        ST_P_CARRY = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } seq_state_e;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic              wide;
        logic [WIDE_W-1:0] a;
        logic [WIDE_W-1:0] b;
    } alu_req_t;

    // Carry-using and compare commands run on the plain ALU add/subtract.
    function automatic logic [CMD_W-1:0] base_cmd(input logic [CMD_W-1:0] cmd);
        case (cmd)
            CMD_ADC: base_cmd = CMD_ADD;
            CMD_SBC: base_cmd = CMD_SUB;
            CMD_CP:  base_cmd = CMD_SUB;
            default: base_cmd = cmd;
        endcase
    endfunction

endpackage

// File: rtl/alu_flag_compose.sv
// Combinational Game Boy flag composition from the final pass result and the
// accumulated half-carry / carry of all passes.
module alu_flag_compose
    import gb_alu_pkg::*;
(
    input  logic [CMD_W-1:0]  cmd_i,
    input  logic              wide_i,
    input  logic [DATA_W-1:0] r_i,
    input  logic              h_i,
    input  logic              c_i,
    input  logic              z_prev_i,
    output logic [FLAG_W-1:0] flags_c_o
);

    logic r_zero;

    always_comb begin
        flags_c_o = '0;
        r_zero    = (r_i == '0);
        case (cmd_i)
            CMD_ADD, CMD_ADC: begin
                // 16-bit ADD leaves Z alone.
                flags_c_o[FLAG_Z] = wide_i ? z_prev_i : r_zero;
                flags_c_o[FLAG_H] = h_i;
                flags_c_o[FLAG_C] = c_i;
            end
            CMD_SUB, CMD_SBC, CMD_CP: begin
                flags_c_o[FLAG_Z] = r_zero;
                flags_c_o[FLAG_N] = 1'b1;
                flags_c_o[FLAG_H] = h_i;
                flags_c_o[FLAG_C] = c_i;
            end
            CMD_AND: begin
                flags_c_o[FLAG_Z] = r_zero;
                flags_c_o[FLAG_H] = 1'b1;
            end
            default: begin
                flags_c_o[FLAG_Z] = r_zero;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-pass controller in front of the 8-bit ALU: builds ADC/SBC and 16-bit
// ADD from chained passes and owns the architectural {Z,N,H,C} register.
module alu_sequencer
    import gb_alu_pkg::*;
#(
    parameter logic [3:0] F_INIT = 4'b1011
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CMD_W-1:0]  req_cmd,
    input  logic              req_wide,
    input  logic [WIDE_W-1:0] req_a,
    input  logic [WIDE_W-1:0] req_b,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [WIDE_W-1:0] rsp_result,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_h,
    output logic              flag_c,
    input  logic              flags_we,
    input  logic [FLAG_W-1:0] flags_wdata,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [CMD_W-1:0]  alu_cmd,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_z,
    input  logic              alu_h,
    input  logic              alu_c
);

    seq_state_e        state_q, state_d;
    alu_req_t          req_q, req_d;
    logic              cin_q, cin_d;
    logic [DATA_W-1:0] res_lo_q, res_lo_d;
    logic              c_lo_q, c_lo_d;
    logic              h1_q, h1_d;
    logic              c1_q, c1_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [WIDE_W-1:0] rsp_result_q, rsp_result_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;

    logic              fc_h, fc_c;
    logic [FLAG_W-1:0] fc_flags;
    logic [WIDE_W-1:0] fin_result;
    logic              need_carry;

    // Z is recomputed from the final composed byte, so the ALU zero flag is not needed.
    logic unused_alu_z;
    assign unused_alu_z = alu_z;

    alu_flag_compose u_flag_compose (
        .cmd_i     (req_q.cmd),
        .wide_i    (req_q.wide),
        .r_i       (alu_result),
        .h_i       (fc_h),
        .c_i       (fc_c),
        .z_prev_i  (flags_q[FLAG_Z]),
        .flags_c_o (fc_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            cin_q        <= 1'b0;
            res_lo_q     <= '0;
            c_lo_q       <= 1'b0;
            h1_q         <= 1'b0;
            c1_q         <= 1'b0;
            flags_q      <= F_INIT;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            cmd_q        <= CMD_ADD;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            cin_q        <= cin_d;
            res_lo_q     <= res_lo_d;
            c_lo_q       <= c_lo_d;
            h1_q         <= h1_d;
            c1_q         <= c1_d;
            flags_q      <= flags_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_result_q <= rsp_result_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            cmd_q        <= cmd_d;
        end
    end

    // Final pass results are composed on the way into DONE so that rsp_valid,
    // rsp_result and the flags all become visible in the DONE cycle.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        cin_d        = cin_q;
        res_lo_d     = res_lo_q;
        c_lo_d       = c_lo_q;
        h1_d         = h1_q;
        c1_d         = c1_q;
        flags_d      = flags_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_result_d = rsp_result_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        cmd_d        = CMD_ADD;
        fc_h         = alu_h;
        fc_c         = alu_c;
        need_carry   = req_q.wide || (req_q.cmd == CMD_ADC) || (req_q.cmd == CMD_SBC);

        if (req_q.wide) begin
            fin_result = {alu_result, res_lo_q};
        end else if (req_q.cmd == CMD_CP) begin
            fin_result = {8'h00, req_q.a[7:0]};
        end else begin
            fin_result = {8'h00, alu_result};
        end

        case (state_q)
            ST_IDLE: begin
                if (flags_we) begin
                    flags_d = flags_wdata;
                end
                if (req_valid) begin
                    req_d = '{cmd: req_cmd, wide: req_wide, a: req_a, b: req_b};
                    cin_d = flags_we ? flags_wdata[FLAG_C] : flags_q[FLAG_C];
                    if (req_wide && (req_cmd != CMD_ADD)) begin
                        state_d     = ST_ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_wide) begin
                        state_d = ST_P_LO;
                        op1_d   = req_a[7:0];
                        op2_d   = req_b[7:0];
                    end else begin
                        state_d = ST_P_HI;
                        op1_d   = req_a[7:0];
                        op2_d   = req_b[7:0];
                        cmd_d   = base_cmd(req_cmd);
                    end
                end
            end
            ST_P_LO: begin
                res_lo_d = alu_result;
                c_lo_d   = alu_c;
                state_d  = ST_P_HI;
                op1_d    = req_q.a[15:8];
                op2_d    = req_q.b[15:8];
            end
            ST_P_HI: begin
                h1_d = alu_h;
                c1_d = alu_c;
                if (need_carry) begin
                    state_d = ST_P_CARRY;
                    op1_d   = alu_result;
                    op2_d   = {7'b0, (req_q.wide ? c_lo_q : cin_q)};
                    cmd_d   = (req_q.cmd == CMD_SBC) ? CMD_SUB : CMD_ADD;
                end else begin
                    state_d      = ST_DONE;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = fin_result;
                    flags_d      = fc_flags;
                end
            end
            ST_P_CARRY: begin
                fc_h         = h1_q | alu_h;
                fc_c         = c1_q | alu_c;
                state_d      = ST_DONE;
                rsp_valid_d  = 1'b1;
                rsp_result_d = fin_result;
                flags_d      = fc_flags;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_result = rsp_result_q;
    assign flag_z     = flags_q[FLAG_Z];
    assign flag_n     = flags_q[FLAG_N];
    assign flag_h     = flags_q[FLAG_H];
    assign flag_c     = flags_q[FLAG_C];
    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign alu_cmd    = cmd_q;

endmodule
